// File: rtl/logarithm_pkg.sv
// Shared widths and FSM state encoding for the integer logarithm engine.
package logarithm_pkg;

  localparam int unsigned W_P    = 15;
  localparam int unsigned W_X    = 4;
  localparam int unsigned W_A    = 4;
  localparam int unsigned W_PROD = W_P + W_X;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    LOAD   = 3'b001,
    CALC   = 3'b010,
    FINISH = 3'b011
  } state_t;

endpackage

// File: rtl/logarithm_if.sv
// Load/start/done handshake bundle of the logarithm engine.
// With LOGARITHM_REMAINDER_EN defined, the bundle also carries the remainder o_R.
interface logarithm_if;
  import logarithm_pkg::*;

  logic           i_load;
  logic           i_start;
  logic [W_P-1:0] i_P;
  logic [W_X-1:0] i_X;
  logic           o_done;
  logic [W_A-1:0] o_A;
  logic           o_exact;
  logic           o_err;
`ifdef LOGARITHM_REMAINDER_EN
  logic [W_P-1:0] o_R;

  modport master (
    output i_load, i_start, i_P, i_X,
    input  o_done, o_A, o_exact, o_err, o_R
  );
  modport slave (
    input  i_load, i_start, i_P, i_X,
    output o_done, o_A, o_exact, o_err, o_R
  );
`else
  modport master (
    output i_load, i_start, i_P, i_X,
    input  o_done, o_A, o_exact, o_err
  );
  modport slave (
    input  i_load, i_start, i_P, i_X,
    output o_done, o_A, o_exact, o_err
  );
`endif

endinterface

// File: rtl/logarithm_mul_cmp.sv
// One step of the power search: full-width acc*X and compare against P.
module log_mul_cmp
  import logarithm_pkg::*;
(
  input  logic [W_P-1:0] acc,
  input  logic [W_X-1:0] x,
  input  logic [W_P-1:0] p,
  output logic [W_P-1:0] next_acc,
  output logic           cont
);

  logic [W_PROD-1:0] prod;

  // The product is kept at W_P+W_X bits so a step past P never wraps.
  always_comb begin
    prod     = W_PROD'(acc) * W_PROD'(x);
    cont     = (prod <= W_PROD'(p));
    next_acc = prod[W_P-1:0];
  end

endmodule

// File: rtl/logarithm.sv
// Integer logarithm engine: A = floor(log_X(P)) by repeated multiplication.
// Optional remainder output o_R = P - X^A under macro LOGARITHM_REMAINDER_EN.
module logarithm
  import logarithm_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  logarithm_if.slave  bus
);

  state_t         state;
  logic [W_P-1:0] reg_P;
  logic [W_X-1:0] reg_X;
  logic [W_P-1:0] acc;
  logic [W_A-1:0] counter;
  logic           err;

  logic           done_q;
  logic [W_A-1:0] a_q;
  logic           exact_q;
  logic           err_q;

  logic [W_P-1:0] next_acc;
  logic           cont;
  logic           bad_ops;

  log_mul_cmp u_mul_cmp (
    .acc      (acc),
    .x        (reg_X),
    .p        (reg_P),
    .next_acc (next_acc),
    .cont     (cont)
  );

  assign bad_ops = (reg_X < W_X'(2)) || (reg_P == '0);

`ifdef LOGARITHM_REMAINDER_EN
  logic [W_P-1:0] r_q;
  assign bus.o_R = r_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      reg_P   <= '0;
      reg_X   <= '0;
      acc     <= W_P'(1);
      counter <= '0;
      err     <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      exact_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOGARITHM_REMAINDER_EN
      r_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_q  <= 1'b0;
          a_q     <= '0;
          exact_q <= 1'b0;
          err_q   <= 1'b0;
`ifdef LOGARITHM_REMAINDER_EN
          r_q     <= '0;
`endif
          acc     <= W_P'(1);
          counter <= '0;
          err     <= 1'b0;
          if (bus.i_load) begin
            reg_P <= bus.i_P;
            reg_X <= bus.i_X;
            state <= LOAD;
          end
        end

        LOAD: begin
          if (bus.i_start) state <= CALC;
        end

        // Operands are constant in CALC, so testing bad_ops on every active
        // cycle is equivalent to testing it only on the first one.
        CALC: begin
          if (!bus.i_start) begin
            if (bad_ops) begin
              err     <= 1'b1;
              counter <= '0;
              state   <= FINISH;
            end else if (cont) begin
              acc     <= next_acc;
              counter <= counter + W_A'(1);
            end else begin
              state <= FINISH;
            end
          end
        end

        FINISH: begin
          done_q  <= 1'b1;
          a_q     <= counter;
          exact_q <= (acc == reg_P) && !err;
          err_q   <= err;
`ifdef LOGARITHM_REMAINDER_EN
          r_q     <= err ? '0 : (reg_P - acc);
`endif
          if (bus.i_start) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_done  = done_q;
  assign bus.o_A     = a_q;
  assign bus.o_exact = exact_q;
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_logarithm.sv
// Self-checking bench for logarithm: directed operand vectors against a
// power-search reference model, with per-cycle result checking.
module tb_logarithm;

  logic clk;
  logic rst_n;

  logarithm_if bus ();

  logarithm dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cmp_total = 0;
  int cmp_bad   = 0;

  bit exp_on = 1'b0;
  int exp_a, exp_r;
  bit exp_ex, exp_er;

  // A is the largest k with X**k <= P; remainder is P - X**A.
  function automatic void model(input int p, input int x,
                                output int a, output bit ex,
                                output bit er, output int r);
    longint pw;
    if (x < 2 || p == 0) begin
      a = 0; ex = 1'b0; er = 1'b1; r = 0;
    end else begin
      a = 0;
      for (int k = 0; k < 16; k++) begin
        pw = 1;
        for (int j = 0; j < k; j++) pw = pw * x;
        if (pw <= p) a = k;
      end
      pw = 1;
      for (int j = 0; j < a; j++) pw = pw * x;
      ex = (pw == p);
      er = 1'b0;
      r  = p - int'(pw);
    end
  endfunction

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic chk_zero(input string name);
    int v;
    v = {28'd0, bus.o_done, bus.o_exact, bus.o_err, 1'b0} | int'(bus.o_A);
`ifdef LOGARITHM_REMAINDER_EN
    v = v | int'(bus.o_R);
`endif
    check_int(name, v, 0);
  endtask

  // Compare process: while a result is expected, every cycle with o_done
  // high must carry the modelled result; otherwise o_done must stay low.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_on && bus.o_done) begin
        cmp_total++;
        if (int'(bus.o_A) != exp_a || bus.o_exact != exp_ex || bus.o_err != exp_er
`ifdef LOGARITHM_REMAINDER_EN
            || int'(bus.o_R) != exp_r
`endif
           ) begin
          cmp_bad++;
          $display("FAIL result: got A=%0d exact=%0b err=%0b expected A=%0d exact=%0b err=%0b",
                   bus.o_A, bus.o_exact, bus.o_err, exp_a, exp_ex, exp_er);
        end
      end else if (!exp_on) begin
        cmp_total++;
        if (bus.o_done !== 1'b0) begin
          cmp_bad++;
          $display("FAIL idle_done: got %b expected 0", bus.o_done);
        end
      end
    end
  end

  task automatic run(input int p, input int x, input bit stall, input bit ack);
    int cyc;
    int lat;
    model(p, x, exp_a, exp_ex, exp_er, exp_r);
    lat = exp_a + 2 + (stall ? 5 : 0);
    exp_on = 1'b1;
    bus.i_P = p[14:0]; bus.i_X = x[3:0]; bus.i_load = 1'b1;
    @(negedge clk);
    bus.i_load = 1'b0;
    bus.i_P = ~p[14:0]; bus.i_X = ~x[3:0];
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    cyc = 0;
    while (!bus.o_done && cyc < 200) begin
      if (stall && cyc == 3) begin bus.i_start = 1'b1; bus.i_load = 1'b1; end
      if (stall && cyc == 4) bus.i_load = 1'b0;
      if (stall && cyc == 8) bus.i_start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check_int($sformatf("latency P=%0d X=%0d", p, x), cyc, lat);
    repeat (2) @(negedge clk);
    if (ack) begin
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      @(negedge clk);
      chk_zero("ack_clear");
      exp_on = 1'b0;
    end
  endtask

  initial begin
    int a, r;
    bit ex, er;
    rst_n = 1'b0;
    bus.i_load = 1'b0; bus.i_start = 1'b0; bus.i_P = '0; bus.i_X = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    model(1024, 2, a, ex, er, r);  check_int("model_1024_2_A", a, 10);
    check_int("model_1024_2_ex", int'(ex), 1);
    model(100, 3, a, ex, er, r);   check_int("model_100_3_R", r, 19);
    model(32767, 15, a, ex, er, r); check_int("model_32767_15_R", r, 29392);
    model(32767, 2, a, ex, er, r); check_int("model_32767_2_A", a, 14);
    check_int("model_32767_2_R", r, 16383);

    run(1024, 2, 0, 1);
    run(100, 3, 0, 1);
    run(32767, 15, 0, 1);
    run(32767, 2, 0, 1);
    run(5, 1, 0, 1);
    run(0, 7, 0, 1);
    run(1, 7, 0, 1);
    run(3, 5, 0, 1);
    run(1, 0, 0, 1);
    run(1024, 2, 1, 1);

    // Reset during CALC: outputs stay clear and the engine accepts a new load.
    bus.i_P = 15'd1024; bus.i_X = 4'd2; bus.i_load = 1'b1;
    @(negedge clk);
    bus.i_load = 1'b0; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_mid_calc");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(8, 2, 0, 1);

    // Reset while a result is on the outputs must clear them without a clock edge.
    run(27, 3, 0, 0);
    check_int("done_before_reset", int'(bus.o_done), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset_clear");
    exp_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(243, 3, 0, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total + cmp_total, bad + cmp_bad);
    $finish;
  end

endmodule
